// File: rtl/cic_decimator_if.sv
// rtl/cic_decimator_if.sv - sample stream bundle for cic_decimator; sat_flag exists only with CIC_DECIMATOR_SAT_EN
interface cic_decimator_if #(
   parameter int BIT_WIDTH = 4,
   parameter int OUT_WIDTH = 4
);
   logic                        enable;
   logic signed [BIT_WIDTH-1:0] data_in;
   logic signed [OUT_WIDTH-1:0] data_out;
   logic                        data_valid;
`ifdef CIC_DECIMATOR_SAT_EN
   logic                        sat_flag;
`endif

   modport master (
      output enable,
      output data_in,
      input  data_out,
      input  data_valid
`ifdef CIC_DECIMATOR_SAT_EN
      ,
      input  sat_flag
`endif
   );

   modport slave (
      input  enable,
      input  data_in,
      output data_out,
      output data_valid
`ifdef CIC_DECIMATOR_SAT_EN
      ,
      output sat_flag
`endif
   );
endinterface

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - N-stage CIC decimator (M=1); CIC_DECIMATOR_SAT_EN clamps the output instead of wrapping
module cic_decimator #(
   parameter int BIT_WIDTH       = 4,
   parameter int STAGES          = 3,
   parameter int DECIM_RATE      = 4,
   parameter int OUT_SCALE_SHIFT = 6,
   parameter int OUT_WIDTH       = 4
) (
   input  logic           clk,
   input  logic           rst,
   cic_decimator_if.slave bus
);
   localparam int LOG2_R = $clog2(DECIM_RATE);
   localparam int ACC_W  = BIT_WIDTH + STAGES * LOG2_R;

   typedef logic signed [ACC_W-1:0] acc_t;

   acc_t              integ_reg  [STAGES];
   acc_t              comb_delay [STAGES];
   acc_t              y          [STAGES+1];
   acc_t              din_ext;
   logic [LOG2_R-1:0] phase;
   logic              dec_event;
   logic [OUT_WIDTH-1:0] next_out;

   assign din_ext   = {{(ACC_W-BIT_WIDTH){bus.data_in[BIT_WIDTH-1]}}, bus.data_in};
   assign dec_event = bus.enable && (phase == LOG2_R'(DECIM_RATE - 1));

   // Comb chain works on pre-update integrator/delay values; registered only on dec_event.
   always_comb begin
      y[0] = integ_reg[STAGES-1];
      for (int i = 1; i <= STAGES; i++) begin
         y[i] = y[i-1] - comb_delay[i-1];
      end
   end

`ifdef CIC_DECIMATOR_SAT_EN
   localparam acc_t OUT_MAX = acc_t'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam acc_t OUT_MIN = acc_t'(-(2 ** (OUT_WIDTH - 1)));

   acc_t shifted;
   logic next_sat;

   always_comb begin
      shifted  = y[STAGES] >>> OUT_SCALE_SHIFT;
      next_sat = 1'b0;
      next_out = shifted[OUT_WIDTH-1:0];
      if (shifted > OUT_MAX) begin
         next_out = OUT_MAX[OUT_WIDTH-1:0];
         next_sat = 1'b1;
      end else if (shifted < OUT_MIN) begin
         next_out = OUT_MIN[OUT_WIDTH-1:0];
         next_sat = 1'b1;
      end
   end
`else
   assign next_out = OUT_WIDTH'(y[STAGES] >>> OUT_SCALE_SHIFT);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            integ_reg[i]  <= '0;
            comb_delay[i] <= '0;
         end
         phase          <= '0;
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
`ifdef CIC_DECIMATOR_SAT_EN
         bus.sat_flag   <= 1'b0;
`endif
      end else begin
         bus.data_valid <= 1'b0;
`ifdef CIC_DECIMATOR_SAT_EN
         bus.sat_flag   <= 1'b0;
`endif
         if (bus.enable) begin
            integ_reg[0] <= integ_reg[0] + din_ext;
            for (int i = 1; i < STAGES; i++) begin
               integ_reg[i] <= integ_reg[i] + integ_reg[i-1];
            end
            phase <= phase + LOG2_R'(1);
         end
         if (dec_event) begin
            for (int i = 0; i < STAGES; i++) begin
               comb_delay[i] <= y[i];
            end
            bus.data_out   <= next_out;
            bus.data_valid <= 1'b1;
`ifdef CIC_DECIMATOR_SAT_EN
            bus.sat_flag   <= next_sat;
`endif
         end
      end
   end
endmodule
